// File: rtl/n_port_alloc_ctrl.sv
// ============================================================================
// Module      : n_port_alloc_ctrl
// Description : North output port wormhole allocator. Round-robin arbitration
//               over s/w/e/l inputs, packet-long grant hold, credit tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n_port_alloc_ctrl #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CW           = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req_i,
  input  logic [3:0]    tail_i,
  input  logic          credit_return_i,
  output logic [3:0]    gnt_o,
  output logic [2:0]    sel_o,
  output logic          xfer_o,
  output logic          change_order_o,
  output logic [CW-1:0] credit_cnt_o,
  output logic          err_o
);

  localparam logic [0:0]    c_st_idle = 1'b0;
  localparam logic [0:0]    c_st_lock = 1'b1;
  localparam logic [CW-1:0] c_depth   = CW'(CREDIT_DEPTH);
  localparam logic [1:0]    c_idx_l   = 2'd0;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [3:0]    r_gnt;
  logic [2:0]    r_sel;
  logic [1:0]    r_gidx;
  logic [1:0]    r_ptr;
  logic          r_change;
  logic          r_err;
  logic [CW-1:0] r_credit;

  logic          w_have_credit;
  logic          w_win_found;
  logic [1:0]    w_win_idx;
  logic [1:0]    w_cand;
  logic          w_grant;
  logic          w_xfer;
  logic          w_release;
  logic          w_cr_inc;
  logic          w_cr_dec;

  assign w_have_credit = (r_credit != '0);

  // Cyclic search s -> w -> e -> l starting just after the last winner.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = 2'd0;
    w_cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_cand = r_ptr - 2'(i);
      if (!w_win_found && req_i[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_grant)   w_state_nxt = c_st_lock;
      c_st_lock: if (w_release) w_state_nxt = c_st_idle;
      default:                  w_state_nxt = c_st_idle;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_grant   = 1'b0;
    w_xfer    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_grant = w_win_found && w_have_credit;
      end
      c_st_lock: begin
        w_xfer    = (|(req_i & r_gnt)) && w_have_credit;
        w_release = w_xfer && (|(tail_i & r_gnt));
      end
      default: begin
        w_grant = 1'b0;
      end
    endcase
  end

  assign w_cr_dec = w_xfer && !credit_return_i;
  assign w_cr_inc = credit_return_i && !w_xfer;

  // Grant, select and priority pointer; held unchanged across the packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt    <= 4'b0000;
      r_sel    <= 3'd0;
      r_gidx   <= 2'd0;
      r_ptr    <= c_idx_l;
      r_change <= 1'b0;
    end else begin
      r_change <= w_release;
      if (w_grant) begin
        r_gnt         <= 4'b0000;
        r_gnt[w_win_idx] <= 1'b1;
        r_sel         <= 3'd4 - {1'b0, w_win_idx};
        r_gidx        <= w_win_idx;
      end else if (w_release) begin
        r_gnt <= 4'b0000;
        r_sel <= 3'd0;
        r_ptr <= r_gidx;
      end
    end
  end

  // Credit counter; a return into a full counter is an upstream protocol error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit <= c_depth;
      r_err    <= 1'b0;
    end else begin
      if (w_cr_dec) begin
        r_credit <= r_credit - 1'b1;
      end else if (w_cr_inc) begin
        if (r_credit == c_depth) begin
          r_err <= 1'b1;
        end else begin
          r_credit <= r_credit + 1'b1;
        end
      end
    end
  end

  assign gnt_o          = r_gnt;
  assign sel_o          = r_sel;
  assign xfer_o         = w_xfer;
  assign change_order_o = r_change;
  assign credit_cnt_o   = r_credit;
  assign err_o          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_n_port_alloc_ctrl.sv
// ============================================================================
// Module      : tb_n_port_alloc_ctrl
// Description : Vector-table bench for the north port allocation controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n_port_alloc_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req_i = 4'b0000;
  logic [3:0]    tail_i = 4'b0000;
  logic          credit_return_i = 1'b0;
  logic [3:0]    gnt_o;
  logic [2:0]    sel_o;
  logic          xfer_o;
  logic          change_order_o;
  logic [CW-1:0] credit_cnt_o;
  logic          err_o;

  always #5 clk = ~clk;

  n_port_alloc_ctrl #(.CREDIT_DEPTH(4), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_i           (req_i),
    .tail_i          (tail_i),
    .credit_return_i (credit_return_i),
    .gnt_o           (gnt_o),
    .sel_o           (sel_o),
    .xfer_o          (xfer_o),
    .change_order_o  (change_order_o),
    .credit_cnt_o    (credit_cnt_o),
    .err_o           (err_o)
  );

  typedef struct packed {
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    tail;
    logic          cret;
    logic [3:0]    e_gnt;
    logic [2:0]    e_sel;
    logic          e_xfer;
    logic          e_chg;
    logic [CW-1:0] e_cnt;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] tl,
                              input logic cr, input logic [3:0] g, input logic [2:0] s,
                              input logic x, input logic ch, input logic [CW-1:0] cn,
                              input logic er);
    vec_t v;
    v = '{r, rq, tl, cr, g, s, x, ch, cn, er};
    vecs.push_back(v);
  endfunction

  // Fields packed as {gnt, sel, xfer, chg, cnt, err}
  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {gnt_o, sel_o, xfer_o, change_order_o, credit_cnt_o, err_o};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b sel=%0d xfer=%b chg=%b cnt=%0d err=%b, expected gnt=%b sel=%0d xfer=%b chg=%b cnt=%0d err=%b",
               name, act[12:9], act[8:6], act[5], act[4], act[3:1], act[0],
               exp[12:9], exp[8:6], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  initial begin
    int cyc;
    //   rst  req      tail     cr   gnt      sel  xf   chg  cnt  err
    add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0);
    // s streams until credits run out, then trickle credits and release
    add(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd4, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd3, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd2, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd1, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b1000, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd1, 1'b0);
    add(1'b1, 4'b1111, 4'b1000, 1'b1, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd1, 1'b0);
    // rotation s -> w -> e -> l -> s with single-flit packets
    add(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b1, 4'b1111, 4'b0100, 1'b1, 4'b0100, 3'd2, 1'b1, 1'b0, 3'd2, 1'b0);
    add(1'b1, 4'b1111, 4'b0010, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b1, 4'b1111, 4'b0010, 1'b1, 4'b0010, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0);
    add(1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0);
    add(1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0001, 3'd4, 1'b1, 1'b0, 3'd4, 1'b0);
    add(1'b1, 4'b1111, 4'b1000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0);
    add(1'b1, 4'b1111, 4'b1000, 1'b1, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd4, 1'b0);
    // overflowing return sets sticky err
    add(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1);
    // wormhole stall on w while s requests
    add(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1);
    add(1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0, 3'd4, 1'b1);
    add(1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0, 3'd4, 1'b1);
    add(1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0, 3'd4, 1'b1);
    add(1'b1, 4'b1100, 4'b0100, 1'b0, 4'b0100, 3'd2, 1'b1, 1'b0, 3'd4, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1);
    // reset clears err; drain all credits with an l packet
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0);
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0);
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd4, 1'b1, 1'b0, 3'd4, 1'b0);
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd4, 1'b1, 1'b0, 3'd3, 1'b0);
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd4, 1'b1, 1'b0, 3'd2, 1'b0);
    add(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 3'd4, 1'b1, 1'b0, 3'd1, 1'b0);
    // zero credits blocks grant until one returns
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    add(1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    add(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 3'd4, 1'b1, 1'b0, 3'd1, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    // s packet moves pointer to s, then w starts a 5-flit packet
    add(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 4'b1000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    add(1'b1, 4'b1000, 4'b1000, 1'b1, 4'b1000, 3'd1, 1'b1, 1'b0, 3'd2, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0);
    add(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 3'd2, 1'b1, 1'b0, 3'd4, 1'b0);
    add(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 3'd2, 1'b1, 1'b0, 3'd3, 1'b0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset           = vecs[i].rst_n;
      req_i           = vecs[i].req;
      tail_i          = vecs[i].tail;
      credit_return_i = vecs[i].cret;
      #2;
      check($sformatf("vec%0d", i), {vecs[i].e_gnt, vecs[i].e_sel, vecs[i].e_xfer,
                                     vecs[i].e_chg, vecs[i].e_cnt, vecs[i].e_err});
      @(posedge clk);
      #1;
    end

    // Asynchronous reset after two flits of the w packet drops the lock at once
    reset           = 1'b0;
    req_i           = 4'b0100;
    tail_i          = 4'b0000;
    credit_return_i = 1'b0;
    #2;
    check("midpkt_reset", {4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0});
    @(posedge clk);
    #1;

    // Pointer must be back at l, so s beats w
    reset = 1'b1;
    req_i = 4'b1100;
    cyc   = 0;
    while (gnt_o == 4'b0000 && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL grant_latency_after_reset: got %0d cycles, expected 1", cyc);
    end
    #1;
    check("ptr_after_reset", {4'b1000, 3'd1, 1'b1, 1'b0, 3'd4, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
